// File: rtl/fetch_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fetch_mem_arbiter_pkg
//   Shared definitions for the fetch/load-store memory arbiter:
//   - arb_state_e : arbiter FSM state encoding (also exported on the debug port)
//   - BE_W        : byte-enable width of the memory port
//   - IF_BE       : byte enables used for every instruction fetch (full word)
// ---------------------------------------------------------------------------
package fetch_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2
  } arb_state_e;

  localparam int BE_W = 4;

  // Instruction fetches always read a whole word.
  localparam logic [BE_W-1:0] IF_BE = 4'hF;

endpackage

// File: rtl/fetch_mem_arbiter_age_counter.sv
// ---------------------------------------------------------------------------
// fetch_mem_arbiter_age_counter
//   Saturating starvation counter. Counts load/store grants that were issued
//   while a fetch request was waiting; cleared when fetch is granted.
//   Ports:
//     clk, reset   clock (rising edge), asynchronous active-low reset
//     i_inc        count one more starving LS grant
//     i_clr        clear (fetch granted); wins over i_inc
//     o_count      current count, saturates at MAX
//     o_at_max     count has reached MAX: fetch must be granted next
// ---------------------------------------------------------------------------
module fetch_mem_arbiter_age_counter #(
  parameter int MAX   = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_at_max
);

  logic [CNT_W-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == CNT_W'(MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_at_max = w_at_max;

endmodule

// File: rtl/fetch_mem_arbiter.sv
// ---------------------------------------------------------------------------
// fetch_mem_arbiter
//   Shares one single-port memory between instruction fetch (IF) and
//   load/store (LS). Requests are serialised: one transaction is in flight at
//   a time, the memory handshake is sequenced here and the read data is
//   returned to the requester that owns the transaction.
//
//   Optional feature: define FAIRNESS_EN to bound IF starvation. With it,
//   after STARVE_MAX consecutive LS grants issued while IF was waiting, the
//   next grant goes to IF even if LS is requesting. Without it, LS always has
//   priority (the later pipeline stage must not be blocked by fetch).
//
//   Ports:
//     clk, reset          clock (rising edge), asynchronous active-low reset
//     i_if_req/i_if_addr  IF read request (held until o_if_gnt)
//     o_if_gnt            IF accepted (1 cycle)
//     o_if_rvalid/rdata   IF read data return (1 cycle pulse, registered)
//     o_if_stall          fetch stall: IF requesting and data not returning
//     i_ls_*              LS request, we, addr, wdata, byte enables
//     o_ls_gnt            LS accepted (1 cycle)
//     o_ls_rvalid/rdata   LS completion (rdata is 0 for writes)
//     o_mem_*             memory request, held until i_mem_ack (registered)
//     i_mem_ack/rdata     memory completion (1 cycle) with read data
//     o_dbg_state         current FSM state (arb_state_e encoding)
//     o_dbg_starve_cnt    starvation counter (0 when FAIRNESS_EN undefined)
//
//   Handshake: a requester raises req with stable fields and holds them until
//   the cycle in which gnt is high; fields are captured at the end of that
//   cycle. gnt is a decode of the registered state and the live requests so
//   the capture happens in the same cycle gnt is seen. The memory side sees
//   mem_req held high with stable fields until the cycle mem_ack is high;
//   mem_ack while no transaction is in flight is ignored.
// ---------------------------------------------------------------------------
module fetch_mem_arbiter
  import fetch_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_if_req,
  input  logic [ADDR_W-1:0]               i_if_addr,
  output logic                            o_if_gnt,
  output logic                            o_if_rvalid,
  output logic [DATA_W-1:0]               o_if_rdata,
  output logic                            o_if_stall,
  input  logic                            i_ls_req,
  input  logic                            i_ls_we,
  input  logic [ADDR_W-1:0]               i_ls_addr,
  input  logic [DATA_W-1:0]               i_ls_wdata,
  input  logic [BE_W-1:0]                 i_ls_be,
  output logic                            o_ls_gnt,
  output logic                            o_ls_rvalid,
  output logic [DATA_W-1:0]               o_ls_rdata,
  output logic                            o_mem_req,
  output logic                            o_mem_we,
  output logic [ADDR_W-1:0]               o_mem_addr,
  output logic [DATA_W-1:0]               o_mem_wdata,
  output logic [BE_W-1:0]                 o_mem_be,
  input  logic                            i_mem_ack,
  input  logic [DATA_W-1:0]               i_mem_rdata,
  output logic [1:0]                      o_dbg_state,
  output logic [$clog2(STARVE_MAX+1)-1:0] o_dbg_starve_cnt
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e        r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [BE_W-1:0]   r_mem_be;
  logic              r_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_ls_rvalid;
  logic [DATA_W-1:0] r_ls_rdata;

  logic w_idle;
  logic w_starved;
  logic w_if_pick;
  logic w_if_gnt;
  logic w_ls_gnt;

  // ---------------------------------------------------------------------------
  // Grant decode. Grants only come from IDLE, so the ack cycle of a
  // transaction (still BUSY) can never grant. Gated by reset so no grant
  // pulse is visible while the block is held in reset.
  // ---------------------------------------------------------------------------
  assign w_idle    = (r_state == ST_IDLE) & reset;
  assign w_if_pick = i_if_req & (~i_ls_req | w_starved);
  assign w_if_gnt  = w_idle & w_if_pick;
  assign w_ls_gnt  = w_idle & i_ls_req & ~w_if_pick;

`ifdef FAIRNESS_EN
  logic             w_cnt_inc;
  logic             w_at_max;
  logic [CNT_W-1:0] w_cnt;

  // Only LS grants that overtook a waiting fetch count as starvation.
  assign w_cnt_inc = w_ls_gnt & i_if_req;

  fetch_mem_arbiter_age_counter #(
    .MAX   (STARVE_MAX),
    .CNT_W (CNT_W)
  ) u_age_counter (
    .clk      (clk),
    .reset    (reset),
    .i_inc    (w_cnt_inc),
    .i_clr    (w_if_gnt),
    .o_count  (w_cnt),
    .o_at_max (w_at_max)
  );

  assign w_starved        = w_at_max;
  assign o_dbg_starve_cnt = w_cnt;
`else
  assign w_starved        = 1'b0;
  assign o_dbg_starve_cnt = '0;
`endif

  // ---------------------------------------------------------------------------
  // Transaction FSM. Memory fields are captured at grant and held stable for
  // the whole BUSY phase; read data is registered on mem_ack and returned to
  // the owner with a one-cycle rvalid pulse in the following (IDLE) cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rvalid <= 1'b0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ls_gnt) begin
            r_state     <= ST_BUSY_LS;
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_ls_we;
            r_mem_addr  <= i_ls_addr;
            r_mem_wdata <= i_ls_wdata;
            r_mem_be    <= i_ls_be;
          end else if (w_if_gnt) begin
            r_state     <= ST_BUSY_IF;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= i_if_addr;
            r_mem_wdata <= '0;
            r_mem_be    <= IF_BE;
          end
        end
        ST_BUSY_IF: begin
          if (i_mem_ack) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_if_rvalid <= 1'b1;
            r_if_rdata  <= i_mem_rdata;
          end
        end
        ST_BUSY_LS: begin
          if (i_mem_ack) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_ls_rvalid <= 1'b1;
            // Writes complete with zero data so LS never sees stale bus data.
            r_ls_rdata  <= r_mem_we ? '0 : i_mem_rdata;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_if_gnt    = w_if_gnt;
  assign o_ls_gnt    = w_ls_gnt;
  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_ls_rvalid = r_ls_rvalid;
  assign o_ls_rdata  = r_ls_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_dbg_state = r_state;

  // Fetch stalls for as long as it requests and its data is not arriving.
  assign o_if_stall  = i_if_req & ~r_if_rvalid;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
module tb_fetch_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = $clog2(STARVE_MAX + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt, o_if_rvalid, o_if_stall;
  logic [DATA_W-1:0] o_if_rdata;
  logic              i_ls_req, i_ls_we;
  logic [ADDR_W-1:0] i_ls_addr;
  logic [DATA_W-1:0] i_ls_wdata;
  logic [3:0]        i_ls_be;
  logic              o_ls_gnt, o_ls_rvalid;
  logic [DATA_W-1:0] o_ls_rdata;
  logic              o_mem_req, o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [3:0]        o_mem_be;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_rdata;
  logic [1:0]        o_dbg_state;
  logic [CNT_W-1:0]  o_dbg_starve_cnt;

  fetch_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .o_if_stall(o_if_stall),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .i_ls_be(i_ls_be),
    .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_dbg_state(o_dbg_state), .o_dbg_starve_cnt(o_dbg_starve_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic        owner_ls;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  txn_t              pend_q[$];    // accepted, not yet completed transactions
  logic [DATA_W-1:0] exp_q[$];     // expected return data of completions
  logic [31:0]       mem_words [logic [31:0]];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   starve;
  logic exp_if_rv, exp_ls_rv;
  logic prev_if_gnt, prev_ls_gnt;
  logic if_hold, ls_hold;
  int   if_mode, ls_mode;         // 0 none, 1 random, 2 always request
  int   lat_lo, lat_hi, ack_cnt;
  logic ack_armed;
  int   spur_en;                  // 0 off, 1 random, 2 every idle cycle
  int   obs_if_g, obs_ls_g;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic void mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = mem_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_words[a] = w;
  endfunction

  task automatic model_clear();
    pend_q.delete();
    exp_q.delete();
    starve = 0;
    exp_if_rv = 1'b0; exp_ls_rv = 1'b0;
    prev_if_gnt = 1'b0; prev_ls_gnt = 1'b0;
    if_hold = 1'b0; ls_hold = 1'b0;
    ack_armed = 1'b0; ack_cnt = 0;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic cycle();
    logic       e_if_gnt, e_ls_gnt, e_mem_req, starved;
    logic [1:0] e_state;
    txn_t       t;
    e_mem_req = (pend_q.size() != 0);
    e_state   = 2'd0;
    if (e_mem_req) e_state = pend_q[0].owner_ls ? 2'd2 : 2'd1;

    // requesters: hold until granted, optionally withdraw
    if (prev_if_gnt) if_hold = 1'b0;
    if (prev_ls_gnt) ls_hold = 1'b0;
    if (!if_hold) begin
      if (if_mode == 2 || (if_mode == 1 && $urandom_range(0, 2) == 0)) begin
        if_hold   = 1'b1;
        i_if_addr = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      end
    end else if (if_mode == 1 && $urandom_range(0, 15) == 0) if_hold = 1'b0;
    if (!ls_hold) begin
      if (ls_mode == 2 || (ls_mode == 1 && $urandom_range(0, 2) == 0)) begin
        ls_hold    = 1'b1;
        i_ls_we    = 1'($urandom_range(0, 1));
        i_ls_addr  = 32'h100 + 32'($urandom_range(0, 15)) * 4;
        i_ls_wdata = $urandom();
        i_ls_be    = 4'($urandom_range(1, 15));
      end
    end else if (ls_mode == 1 && $urandom_range(0, 15) == 0) ls_hold = 1'b0;
    i_if_req = if_hold;
    i_ls_req = ls_hold;

    // memory responder
    i_mem_ack   = 1'b0;
    i_mem_rdata = $urandom();
    if (o_mem_req === 1'b1) begin
      if (!ack_armed) begin
        ack_armed = 1'b1;
        ack_cnt   = $urandom_range(lat_lo, lat_hi);
      end
      if (ack_cnt == 0) begin
        i_mem_ack = 1'b1;
        ack_armed = 1'b0;
        if (o_mem_we !== 1'b1) i_mem_rdata = mem_rd(o_mem_addr);
      end else ack_cnt--;
    end else if (spur_en == 2 || (spur_en == 1 && $urandom_range(0, 7) == 0)) begin
      i_mem_ack = 1'b1;
    end

    // expected arbitration decision
`ifdef FAIRNESS_EN
    starved = (starve >= STARVE_MAX);
`else
    starved = 1'b0;
`endif
    e_if_gnt = 1'b0; e_ls_gnt = 1'b0;
    if (pend_q.size() == 0) begin
      if (i_if_req && (!i_ls_req || starved)) e_if_gnt = 1'b1;
      else if (i_ls_req)                      e_ls_gnt = 1'b1;
    end

    #1;
    check("if_gnt", 64'(o_if_gnt), 64'(e_if_gnt));
    check("ls_gnt", 64'(o_ls_gnt), 64'(e_ls_gnt));
    check("mem_req", 64'(o_mem_req), 64'(e_mem_req));
    check("dbg_state", 64'(o_dbg_state), 64'(e_state));
    check("starve_cnt", 64'(o_dbg_starve_cnt), 64'(starve));
    check("if_stall", 64'(o_if_stall), 64'(i_if_req & ~exp_if_rv));
    if (e_mem_req) begin
      t = pend_q[0];
      check("mem_addr", 64'(o_mem_addr), 64'(t.addr));
      check("mem_we", 64'(o_mem_we), 64'(t.we));
      check("mem_be", 64'(o_mem_be), 64'(t.be));
      if (t.we) check("mem_wdata", 64'(o_mem_wdata), 64'(t.wdata));
    end
    check("if_rvalid", 64'(o_if_rvalid), 64'(exp_if_rv));
    check("ls_rvalid", 64'(o_ls_rvalid), 64'(exp_ls_rv));
    if (exp_if_rv) check("if_rdata", 64'(o_if_rdata), 64'(exp_q.pop_front()));
    if (exp_ls_rv) check("ls_rdata", 64'(o_ls_rdata), 64'(exp_q.pop_front()));
    if (o_if_gnt === 1'b1) obs_if_g++;
    if (o_ls_gnt === 1'b1) obs_ls_g++;

    // model state update at the clock edge
    prev_if_gnt = e_if_gnt;
    prev_ls_gnt = e_ls_gnt;
    exp_if_rv = 1'b0; exp_ls_rv = 1'b0;
    if (i_mem_ack && pend_q.size() != 0) begin
      t = pend_q.pop_front();
      if (t.owner_ls) begin
        exp_ls_rv = 1'b1;
        if (t.we) begin
          mem_wr(t.addr, t.wdata, t.be);
          exp_q.push_back('0);
        end else exp_q.push_back(mem_rd(t.addr));
      end else begin
        exp_if_rv = 1'b1;
        exp_q.push_back(mem_rd(t.addr));
      end
    end
    if (e_if_gnt) begin
      pend_q.push_back('{1'b0, 1'b0, i_if_addr, 32'h0, 4'hF});
      starve = 0;
    end
    if (e_ls_gnt) begin
      pend_q.push_back('{1'b1, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_be});
`ifdef FAIRNESS_EN
      if (i_if_req) starve++;
`endif
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int guard;
    model_clear();
    if_mode = 0; ls_mode = 0; spur_en = 0; lat_lo = 0; lat_hi = 0;
    obs_if_g = 0; obs_ls_g = 0;
    i_if_req = 1'b1; i_if_addr = 32'h0; i_ls_req = 1'b1; i_ls_we = 1'b0;
    i_ls_addr = 32'h0; i_ls_wdata = 32'h0; i_ls_be = 4'h0;
    i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset values, requests pending while in reset
    check("rst_if_gnt", 64'(o_if_gnt), 64'd0);
    check("rst_ls_gnt", 64'(o_ls_gnt), 64'd0);
    check("rst_mem_req", 64'(o_mem_req), 64'd0);
    check("rst_mem_we", 64'(o_mem_we), 64'd0);
    check("rst_mem_addr", 64'(o_mem_addr), 64'd0);
    check("rst_mem_be", 64'(o_mem_be), 64'd0);
    check("rst_if_rvalid", 64'(o_if_rvalid), 64'd0);
    check("rst_ls_rvalid", 64'(o_ls_rvalid), 64'd0);
    check("rst_if_rdata", 64'(o_if_rdata), 64'd0);
    check("rst_state", 64'(o_dbg_state), 64'd0);
    check("rst_starve", 64'(o_dbg_starve_cnt), 64'd0);
    check("rst_if_stall", 64'(o_if_stall), 64'd1);
    i_if_req = 1'b0; i_ls_req = 1'b0;
    #1;
    check("rst_if_stall_idle", 64'(o_if_stall), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: lone fetch at 0x10, ack three cycles after mem_req
    lat_lo = 3; lat_hi = 3;
    if_hold = 1'b1; i_if_addr = 32'h10;
    run(8);

    // 2: fetch and LS read 0x200 together, LS wins
    lat_lo = 0; lat_hi = 2;
    if_hold = 1'b1; i_if_addr = 32'h20;
    ls_hold = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h200; i_ls_wdata = 32'h0; i_ls_be = 4'hF;
    run(12);

    // 3: LS partial write to 0x300, then read it back
    ls_hold = 1'b1; i_ls_we = 1'b1; i_ls_addr = 32'h300; i_ls_wdata = 32'hDEADBEEF; i_ls_be = 4'b0011;
    run(8);
    ls_hold = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h300; i_ls_wdata = 32'h0; i_ls_be = 4'hF;
    run(8);

    // 4: both requesters held high; count the first ten grants
    lat_lo = 0; lat_hi = 0;
    if_mode = 2; ls_mode = 2;
    obs_if_g = 0; obs_ls_g = 0;
    guard = 0;
    while ((obs_if_g + obs_ls_g) < 10 && guard < 100) begin
      cycle();
      guard++;
    end
    check("held_grant_timeout", 64'(guard < 100), 64'd1);
`ifdef FAIRNESS_EN
    check("held_if_grants", 64'(obs_if_g), 64'd2);
    check("held_ls_grants", 64'(obs_ls_g), 64'd8);
`else
    check("held_if_grants", 64'(obs_if_g), 64'd0);
    check("held_ls_grants", 64'(obs_ls_g), 64'd10);
`endif
    if_mode = 0; ls_mode = 0;
    run(20);

    // random traffic with withdrawals and stray acks in idle
    if_mode = 1; ls_mode = 1; spur_en = 1; lat_lo = 0; lat_hi = 3;
    run(600);
    if_mode = 0; ls_mode = 0; spur_en = 0;
    run(30);

    // 5: reset while fetch is in flight, then a late ack
    lat_lo = 6; lat_hi = 6;
    if_hold = 1'b1; i_if_addr = 32'h40;
    guard = 0;
    while (!(pend_q.size() != 0 && !pend_q[0].owner_ls) && guard < 20) begin
      cycle();
      guard++;
    end
    check("reach_busy_if", 64'(guard < 20), 64'd1);
    cycle();
    check("busy_before_reset", 64'(o_dbg_state), 64'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_mem_req", 64'(o_mem_req), 64'd0);
    check("rst_mid_state", 64'(o_dbg_state), 64'd0);
    check("rst_mid_if_gnt", 64'(o_if_gnt), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    i_if_req = 1'b0; i_ls_req = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    i_mem_ack = 1'b0;
    #1;
    check("late_ack_if_rvalid", 64'(o_if_rvalid), 64'd0);
    check("late_ack_ls_rvalid", 64'(o_ls_rvalid), 64'd0);
    check("late_ack_mem_req", 64'(o_mem_req), 64'd0);
    check("late_ack_state", 64'(o_dbg_state), 64'd0);
    model_clear();
    @(posedge clk); #1;
    run(4);

    // 6: acks pulsed every cycle while idle
    spur_en = 2;
    run(6);
    spur_en = 0;
    run(4);

    // one more transaction after the stray acks
    lat_lo = 1; lat_hi = 1;
    if_hold = 1'b1; i_if_addr = 32'h44;
    run(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
